// File: rtl/sonar_ranger_if.sv
// Sensor-side bundle of the sonar ranger: trigger/echo lines, enable and the
// published per-channel distances plus the sample strobe.
interface sonar_ranger_if #(
    parameter int NUM_CH = 4,
    parameter int DIST_W = 10
);
    logic                     enable;
    logic [NUM_CH-1:0]        echo;
    logic [NUM_CH-1:0]        trig;
    logic [NUM_CH*DIST_W-1:0] dist_cm;
    logic [NUM_CH-1:0]        dist_timeout;
    logic                     sample_valid;
    logic [2:0]               sample_ch;
    logic [DIST_W-1:0]        sample_cm;

    modport master (
        input  enable, echo,
        output trig, dist_cm, dist_timeout, sample_valid, sample_ch, sample_cm
    );

    modport slave (
        output enable, echo,
        input  trig, dist_cm, dist_timeout, sample_valid, sample_ch, sample_cm
    );
endinterface

// File: rtl/sonar_ranger.sv
// Round-robin HC-SR04 controller: fires one sensor at a time, times its echo
// and converts the width to centimetres with a subtract-per-cycle divider.
module sonar_ranger #(
    parameter int NUM_CH         = 4,
    parameter int DIST_W         = 10,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 3000000,
    parameter int CYCLES_PER_CM  = 2900
) (
    input  logic           CLOCK_50,
    input  logic           reset_n,
    sonar_ranger_if.master bus
);
    localparam int MAX_TG  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_TG > TRIG_CYCLES) ? MAX_TG : TRIG_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CPCM      = CNT_W'(CYCLES_PER_CM);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_CONVERT, S_DONE, S_GAP
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [DIST_W-1:0]    quo, quo_nxt;
    logic [CH_W-1:0]      ch, ch_nxt;
    logic                 tmo, tmo_nxt;
    logic [NUM_CH-1:0]    trig_nxt;

    logic [NUM_CH-1:0]    echo_meta, echo_sync;
    logic                 echo_act, echo_prev, echo_rise, echo_fall;

    logic [NUM_CH-1:0]        trig_q;
    logic [NUM_CH*DIST_W-1:0] dist_q;
    logic [NUM_CH-1:0]        dist_tmo_q;
    logic                     valid_q;
    logic [2:0]               sample_ch_q;
    logic [DIST_W-1:0]        sample_cm_q;
    logic [DIST_W-1:0]        done_cm;

    // Edges are taken on the active channel only, so a line already high when
    // the channel starts listening never counts as a rise.
    assign echo_act  = echo_sync[ch];
    assign echo_rise = echo_act & ~echo_prev;
    assign echo_fall = ~echo_act & echo_prev;
    assign done_cm   = tmo ? DIST_MAX : quo;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            echo_meta <= '0;
            echo_sync <= '0;
            echo_prev <= 1'b0;
        end else begin
            echo_meta <= bus.echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_act;
        end
    end

    // NOTE: every variable gets its default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        quo_nxt   = quo;
        ch_nxt    = ch;
        tmo_nxt   = tmo;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (bus.enable) state_nxt = S_TRIG;
            end
            S_TRIG: begin
                tmo_nxt = 1'b0;
                quo_nxt = '0;
                if (cnt == TRIG_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT_RISE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT_RISE: begin
                if (echo_rise) begin
                    cnt_nxt   = '0;
                    state_nxt = S_MEASURE;
                end else if (cnt == TO_LAST) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_MEASURE: begin
                // The rise cycle is counted here too, so cnt leaves holding
                // exactly the number of cycles the echo was high.
                if (cnt == TO_LAST) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (echo_fall) state_nxt = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (cnt >= CPCM) begin
                    cnt_nxt = cnt - CPCM;
                    quo_nxt = quo + DIST_W'(1);
                    if (quo_nxt == DIST_MAX) state_nxt = S_DONE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                cnt_nxt   = '0;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt   = '0;
                    ch_nxt    = (ch == CH_LAST) ? '0 : ch + CH_W'(1);
                    state_nxt = bus.enable ? S_TRIG : S_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        trig_nxt = '0;
        for (int i = 0; i < NUM_CH; i++)
            trig_nxt[i] = (state_nxt == S_TRIG) && (ch_nxt == CH_W'(i));
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            quo   <= '0;
            ch    <= '0;
            tmo   <= 1'b0;
            trig_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            quo    <= quo_nxt;
            ch     <= ch_nxt;
            tmo    <= tmo_nxt;
            trig_q <= trig_nxt;
        end
    end

    // NOTE: the per-channel result registers are reset along with the control
    // logic, so every published output reads 0 straight out of reset.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            dist_q      <= '0;
            dist_tmo_q  <= '0;
            valid_q     <= 1'b0;
            sample_ch_q <= '0;
            sample_cm_q <= '0;
        end else begin
            valid_q <= (state == S_DONE);
            if (state == S_DONE) begin
                dist_q[int'(ch)*DIST_W +: DIST_W] <= done_cm;
                dist_tmo_q[ch]                    <= tmo;
                sample_ch_q                       <= 3'(ch);
                sample_cm_q                       <= done_cm;
            end
        end
    end

    assign bus.trig         = trig_q;
    assign bus.dist_cm      = dist_q;
    assign bus.dist_timeout = dist_tmo_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.sample_cm    = sample_cm_q;
endmodule

// File: tb/tb_sonar_ranger.sv
// Self-checking bench for sonar_ranger with shortened timing parameters; a
// per-sample reference model predicts channel order, distance and timeout.
module tb_sonar_ranger;
    localparam int NUM_CH         = 4;
    localparam int DIST_W         = 5;
    localparam int TRIG_CYCLES    = 20;
    localparam int TIMEOUT_CYCLES = 1200;
    localparam int GAP_CYCLES     = 150;
    localparam int CYCLES_PER_CM  = 29;
    localparam int DIST_MAX       = (1 << DIST_W) - 1;

    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    sonar_ranger_if #(.NUM_CH(NUM_CH), .DIST_W(DIST_W)) bus ();

    sonar_ranger #(
        .NUM_CH(NUM_CH), .DIST_W(DIST_W), .TRIG_CYCLES(TRIG_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GAP_CYCLES(GAP_CYCLES),
        .CYCLES_PER_CM(CYCLES_PER_CM)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Observers: trigger pulses and sample strobes are logged with cycle stamps.
    typedef struct { int cyc; logic [NUM_CH-1:0] vec; int len; } trig_ev_t;
    typedef struct { int cyc; logic [2:0] ch; logic [DIST_W-1:0] cm; } samp_t;

    trig_ev_t          trig_q[$];
    samp_t             samp_q[$];
    trig_ev_t          cur;
    logic [NUM_CH-1:0] trig_prev = '0;
    int                multi_hot = 0;
    int                cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if ($countones(bus.trig) > 1) multi_hot++;
        if (trig_prev == '0 && bus.trig != '0) begin
            cur.cyc = cyc;
            cur.vec = bus.trig;
            cur.len = 0;
        end
        if (bus.trig != '0) cur.len++;
        if (trig_prev != '0 && bus.trig == '0) trig_q.push_back(cur);
        trig_prev = bus.trig;
        if (bus.sample_valid === 1'b1) samp_q.push_back('{cyc, bus.sample_ch, bus.sample_cm});
    end

    // Reference model: latest result per channel and the round-robin pointer.
    int exp_ch;
    int model_cm[NUM_CH];
    bit model_tmo[NUM_CH];
    int last_valid_cyc;
    bit have_prev;

    function automatic logic [NUM_CH*DIST_W-1:0] model_dist();
        logic [NUM_CH*DIST_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i*DIST_W +: DIST_W] = DIST_W'(model_cm[i]);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_tmo_vec();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) v[i] = model_tmo[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            model_cm[i]  = 0;
            model_tmo[i] = 1'b0;
        end
        exp_ch    = 0;
        have_prev = 1'b0;
    endtask

    task automatic wait_trig(output trig_ev_t ev);
        int n = 0;
        while (trig_q.size() == 0 && n < 4*GAP_CYCLES + 2*TIMEOUT_CYCLES) begin
            @(negedge clk);
            n++;
        end
        check("trig_seen", 64'(trig_q.size() != 0), 64'(1));
        if (trig_q.size() == 0) finish_run();
        ev = trig_q.pop_front();
    endtask

    task automatic wait_sample(output samp_t s);
        int n = 0;
        while (samp_q.size() == 0 && n < 2*TIMEOUT_CYCLES + 200) begin
            @(negedge clk);
            n++;
        end
        check("sample_seen", 64'(samp_q.size() != 0), 64'(1));
        if (samp_q.size() == 0) finish_run();
        s = samp_q.pop_front();
    endtask

    // One ranging cycle on the expected channel. width < 0 means no fresh rise;
    // pre holds the echo high from before the trigger (dropped after delay
    // cycles when a fresh pulse follows). en_off clears enable mid-pulse.
    task automatic do_sample(input bit pre, input int delay, input int width, input int en_off);
        trig_ev_t          ev;
        samp_t             s;
        int                ch;
        bit                e_tmo;
        int                e_cm;
        logic [NUM_CH-1:0] e_vec;
        ch       = exp_ch;
        e_vec    = '0;
        e_vec[ch] = 1'b1;
        if (pre) bus.echo[ch] = 1'b1;
        wait_trig(ev);
        check("trig_ch", 64'(ev.vec), 64'(e_vec));
        check("trig_len", 64'(ev.len), 64'(TRIG_CYCLES));
        if (have_prev) check("done_to_trig_gap", 64'(ev.cyc - last_valid_cyc), 64'(GAP_CYCLES));
        check("trig_onehot", 64'(multi_hot), 64'(0));
        if (pre && width >= 0) begin
            repeat (delay) @(negedge clk);
            bus.echo[ch] = 1'b0;
            repeat (5) @(negedge clk);
        end else if (!pre) begin
            repeat (delay) @(negedge clk);
        end
        if (width >= 0) begin
            bus.echo[ch] = 1'b1;
            for (int i = 0; i < width; i++) begin
                if (i == en_off) bus.enable = 1'b0;
                @(negedge clk);
            end
            bus.echo[ch] = 1'b0;
        end
        wait_sample(s);
        bus.echo[ch] = 1'b0;

        if (width < 0 || width >= TIMEOUT_CYCLES) begin
            e_tmo = 1'b1;
            e_cm  = DIST_MAX;
        end else begin
            e_tmo = 1'b0;
            e_cm  = width / CYCLES_PER_CM;
            if (e_cm > DIST_MAX) e_cm = DIST_MAX;
        end
        model_cm[ch]  = e_cm;
        model_tmo[ch] = e_tmo;

        check("sample_ch", 64'(s.ch), 64'(ch));
        check("sample_cm", 64'(s.cm), 64'(e_cm));
        check("dist_cm", 64'(bus.dist_cm), 64'(model_dist()));
        check("dist_timeout", 64'(bus.dist_timeout), 64'(model_tmo_vec()));
        last_valid_cyc = s.cyc;
        have_prev      = 1'b1;
        repeat (3) @(negedge clk);
        check("single_strobe", 64'(samp_q.size()), 64'(0));
        check("sample_cm_hold", 64'(bus.sample_cm), 64'(e_cm));
        exp_ch = (ch + 1) % NUM_CH;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trig"}, 64'(bus.trig), 64'(0));
        check({tag, "_dist_cm"}, 64'(bus.dist_cm), 64'(0));
        check({tag, "_dist_timeout"}, 64'(bus.dist_timeout), 64'(0));
        check({tag, "_sample_valid"}, 64'(bus.sample_valid), 64'(0));
        check({tag, "_sample_ch"}, 64'(bus.sample_ch), 64'(0));
        check({tag, "_sample_cm"}, 64'(bus.sample_cm), 64'(0));
    endtask

    initial begin
        #1600000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        trig_ev_t ev;
        int       n;
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        bus.echo   = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_without_enable", 64'(bus.trig), 64'(0));
        bus.enable = 1'b1;

        do_sample(1'b0, 10, 290, -1);          // 10 cm
        do_sample(1'b0, 3, 28, -1);            // just below 1 cm
        do_sample(1'b0, 7, 29, -1);            // exactly 1 cm
        do_sample(1'b0, 0, 1199, -1);          // saturates
        do_sample(1'b0, 0, -1, -1);            // never rises
        do_sample(1'b0, 12, 1200, -1);         // width reaches timeout
        do_sample(1'b1, 0, -1, -1);            // held high, no fresh rise
        do_sample(1'b1, 30, 145, -1);          // held high, then fresh rise
        for (int k = 0; k < 10; k++)
            do_sample(1'b0, int'($urandom_range(0, 300)), int'($urandom_range(1, 1100)), -1);

        // Reset in the middle of a measurement on channel 2.
        wait_trig(ev);
        check("pre_reset_trig_ch", 64'(ev.vec), 64'(4'b0100));
        repeat (5) @(negedge clk);
        bus.echo[2] = 1'b1;
        repeat (100) @(negedge clk);
        #3 reset_n = 1'b0;
        #1 check_all_zero("mid_measure_reset");
        bus.echo = '0;
        repeat (3) @(negedge clk);
        trig_q.delete();
        samp_q.delete();
        model_clear();
        reset_n = 1'b1;

        // Restart lands on channel 0; a reset during its trigger drops it at once.
        n = 0;
        while (bus.trig == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("restart_trig_ch0", 64'(bus.trig), 64'(4'b0001));
        #3 reset_n = 1'b0;
        #1 check("async_trig_drop", 64'(bus.trig), 64'(0));
        repeat (2) @(negedge clk);
        trig_q.delete();
        samp_q.delete();
        reset_n = 1'b1;

        do_sample(1'b0, 20, 580, -1);          // ch0, 20 cm
        do_sample(1'b0, 10, 300, 20);          // ch1, enable drops mid-pulse
        repeat (GAP_CYCLES + 300) @(negedge clk);
        check("stopped_trig_events", 64'(trig_q.size()), 64'(0));
        check("stopped_trig", 64'(bus.trig), 64'(0));

        bus.enable = 1'b1;
        have_prev  = 1'b0;
        do_sample(1'b0, int'($urandom_range(0, 300)), int'($urandom_range(1, 1100)), -1);

        finish_run();
    end
endmodule
